// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared widths and pipeline owner tags for the VRAM arbiter
package vram_pkg;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;
endpackage

// File: rtl/vram_arb_pipe.sv
// rtl/vram_arb_pipe.sv - two-stage owner-tag pipeline that steers SPRAM read data
// back to the requester that issued the access.
module vram_arb_pipe
   import vram_pkg::*;
#(
   parameter int DATA_W = vram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  owner_t            issue_tag,
   input  logic              issue_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata
);

   owner_t tag_s1;
   owner_t tag_s2;
   logic   we_s1;
   logic   we_s2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_s1     <= OWN_NONE;
         tag_s2     <= OWN_NONE;
         we_s1      <= 1'b0;
         we_s2      <= 1'b0;
         disp_valid <= 1'b0;
         cpu_ack    <= 1'b0;
         disp_rdata <= '0;
         cpu_rdata  <= '0;
      end else begin
         tag_s1     <= issue_tag;
         we_s1      <= issue_we;
         tag_s2     <= tag_s1;
         we_s2      <= we_s1;
         disp_valid <= (tag_s2 == OWN_DISP);
         cpu_ack    <= (tag_s2 == OWN_CPU);
         // ram_rdata belongs to the stage-2 access; only the owner's register moves
         if (tag_s2 == OWN_DISP)
            disp_rdata <= ram_rdata;
         if (tag_s2 == OWN_CPU && !we_s2)
            cpu_rdata <= ram_rdata;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares one SPRAM between VGA scanout and the CPU screen port,
// display first with a starvation counter that forces a CPU slot.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W       = vram_pkg::ADDR_W,
   parameter int DATA_W       = vram_pkg::DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_en,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic   [3:0] starve_cnt;
   logic         cpu_win;
   logic         disp_win;
   owner_t       issue_tag;

   // Grants are held low during reset so nothing is issued from a stale request.
   always_comb begin
      cpu_win   = 1'b0;
      disp_win  = 1'b0;
      issue_tag = OWN_NONE;
      if (!reset) begin
         if (cpu_req && (!disp_req || starve_cnt == LIMIT)) begin
            cpu_win   = 1'b1;
            issue_tag = OWN_CPU;
         end else if (disp_req) begin
            disp_win  = 1'b1;
            issue_tag = OWN_DISP;
         end
      end
   end

   assign disp_gnt = disp_win;
   assign cpu_gnt  = cpu_win;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_we     <= 1'b0;
         ram_en     <= 1'b0;
         starve_cnt <= '0;
      end else begin
         ram_en    <= cpu_win | disp_win;
         ram_we    <= cpu_win & cpu_we;
         ram_wdata <= (cpu_win && cpu_we) ? cpu_wdata : '0;
         if (cpu_win)
            ram_addr <= cpu_addr;
         else if (disp_win)
            ram_addr <= disp_addr;

         // Counts display grants that made a waiting CPU lose; saturates at the limit.
         if (!cpu_req || cpu_win)
            starve_cnt <= '0;
         else if (disp_win && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

   vram_arb_pipe #(
      .DATA_W(DATA_W)
   ) u_pipe (
      .clk        (clk),
      .reset      (reset),
      .issue_tag  (issue_tag),
      .issue_we   (cpu_win & cpu_we),
      .ram_rdata  (ram_rdata),
      .disp_valid (disp_valid),
      .disp_rdata (disp_rdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata)
   );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter against a transaction-level model
module tb_vram_arbiter;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_req;
   logic [13:0] disp_addr;
   logic        disp_gnt;
   logic        disp_valid;
   logic [15:0] disp_rdata;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic [13:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_we;
   logic        ram_en;
   logic [15:0] ram_rdata = '0;

   always #5 clk = ~clk;

   vram_arbiter #(.ADDR_W(14), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_valid(disp_valid), .disp_rdata(disp_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_en(ram_en),
      .ram_rdata(ram_rdata)
   );

   function automatic logic [15:0] init_val(input logic [13:0] a);
      logic [15:0] t;
      if (a == 14'h0051) return 16'hBEEF;
      t = {2'b00, a} * 16'h9E37;
      return t ^ 16'h5A5A;
   endfunction

   // SPRAM behaviour: registered read, write on enable, unwritten words hold init_val
   logic [15:0] spram  [0:16383];
   bit          sp_wr  [0:16383];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            spram[ram_addr] <= ram_wdata;
            sp_wr[ram_addr] <= 1'b1;
         end
         ram_rdata <= sp_wr[ram_addr] ? spram[ram_addr] : init_val(ram_addr);
      end
   end

   // Reference model: memory contents as of grant order, plus expected completions
   typedef struct {
      int          due;
      bit          disp;
      bit          we;
      logic [15:0] data;
   } exp_t;

   exp_t        q[$];
   logic [15:0] ref_mem [0:16383];
   bit          ref_wr  [0:16383];
   int          cyc = 0;
   int          streak = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   int          n_cgnt = 0;
   logic [15:0] m_disp_rd = '0;
   logic [15:0] m_cpu_rd = '0;
   bit          exp_en = 1'b0;
   bit          exp_we = 1'b0;
   logic [13:0] exp_addr = '0;
   logic [15:0] exp_wdata = '0;
   bit          last_dg = 1'b0;
   bit          last_cg = 1'b0;

   function automatic logic [15:0] ref_rd(input logic [13:0] a);
      return ref_wr[a] ? ref_mem[a] : init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string where);
      chk({where, "_disp_gnt"},   32'(disp_gnt),   32'd0);
      chk({where, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
      chk({where, "_disp_valid"}, 32'(disp_valid), 32'd0);
      chk({where, "_cpu_ack"},    32'(cpu_ack),    32'd0);
      chk({where, "_disp_rdata"}, 32'(disp_rdata), 32'd0);
      chk({where, "_cpu_rdata"},  32'(cpu_rdata),  32'd0);
      chk({where, "_ram_en"},     32'(ram_en),     32'd0);
      chk({where, "_ram_we"},     32'(ram_we),     32'd0);
      chk({where, "_ram_addr"},   32'(ram_addr),   32'd0);
      chk({where, "_ram_wdata"},  32'(ram_wdata),  32'd0);
   endtask

   // One cycle: entered at posedge+1 with inputs already driven, leaves at next posedge+1.
   task automatic tick();
      bit e_cpu, e_disp, dv, ca;
      chk("ram_en", 32'(ram_en), 32'(exp_en));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_en) begin
         chk("ram_addr",  32'(ram_addr),  32'(exp_addr));
         chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
      end
      #2;
      e_cpu  = cpu_req && (!disp_req || streak >= LIMIT);
      e_disp = disp_req && !e_cpu;
      chk("disp_gnt", 32'(disp_gnt), 32'(e_disp));
      chk("cpu_gnt",  32'(cpu_gnt),  32'(e_cpu));
      chk("gnt_excl", 32'(disp_gnt & cpu_gnt), 32'd0);

      dv = 1'b0;
      ca = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         if (q[0].disp) begin
            dv = 1'b1;
            m_disp_rd = q[0].data;
         end else begin
            ca = 1'b1;
            if (!q[0].we) m_cpu_rd = q[0].data;
         end
         void'(q.pop_front());
      end
      chk("disp_valid", 32'(disp_valid), 32'(dv));
      chk("cpu_ack",    32'(cpu_ack),    32'(ca));
      chk("disp_rdata", 32'(disp_rdata), 32'(m_disp_rd));
      chk("cpu_rdata",  32'(cpu_rdata),  32'(m_cpu_rd));

      exp_en    = e_cpu | e_disp;
      exp_we    = e_cpu && cpu_we;
      exp_wdata = exp_we ? cpu_wdata : 16'h0000;
      if (e_cpu) begin
         exp_addr = cpu_addr;
         n_cgnt++;
         if (cpu_we) begin
            ref_mem[cpu_addr] = cpu_wdata;
            ref_wr[cpu_addr]  = 1'b1;
            q.push_back('{cyc + 3, 1'b0, 1'b1, 16'h0000});
         end else begin
            q.push_back('{cyc + 3, 1'b0, 1'b0, ref_rd(cpu_addr)});
         end
      end else if (e_disp) begin
         exp_addr = disp_addr;
         q.push_back('{cyc + 3, 1'b1, 1'b0, ref_rd(disp_addr)});
      end
      if (!cpu_req || e_cpu) streak = 0;
      else if (e_disp && streak < LIMIT) streak++;
      last_dg = e_disp;
      last_cg = e_cpu;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      disp_req = 1'b0;
      cpu_req  = 1'b0;
      cpu_we   = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1;
      disp_req = 1'b0; disp_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("rst");
      reset = 1'b0;

      // display-only read of a preloaded word
      disp_req = 1'b1; disp_addr = 14'h0051;
      tick();
      disp_req = 1'b0;
      tick(); tick();
      chk("beef_valid", 32'(disp_valid), 32'd1);
      chk("beef_data",  32'(disp_rdata), 32'h0000BEEF);
      tick();
      idle(2);

      // CPU write then immediate read-back of the top address
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 16'h1234;
      tick();
      cpu_we = 1'b0; cpu_wdata = 16'h0000;
      tick();
      idle(4);
      chk("raw_data", 32'(cpu_rdata), 32'h00001234);

      // sustained contention: D,D,D,D,C repeating
      n_cgnt = 0;
      disp_req = 1'b1; disp_addr = 14'h0100;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
      for (int i = 0; i < 20; i++) tick();
      chk("starve_cpu_grants", 32'(n_cgnt), 32'd4);
      idle(4);

      // alternating display / CPU reads over random addresses
      for (int i = 0; i < 64; i++) begin
         disp_req = (i % 2 == 0);
         cpu_req  = (i % 2 == 1);
         cpu_we   = 1'b0;
         disp_addr = 14'($urandom);
         cpu_addr  = 14'($urandom);
         tick();
      end
      idle(4);

      // random mixed traffic on a small address window; held requests stay stable
      disp_req = 1'b0; cpu_req = 1'b0;
      for (int i = 0; i < 150; i++) begin
         if (!(disp_req && !last_dg)) begin
            disp_req  = ($urandom_range(0, 2) != 0);
            disp_addr = 14'($urandom_range(0, 31));
         end
         if (!(cpu_req && !last_cg)) begin
            cpu_req   = ($urandom_range(0, 1) != 0);
            cpu_we    = ($urandom_range(0, 1) != 0);
            cpu_addr  = 14'($urandom_range(0, 31));
            cpu_wdata = 16'($urandom);
         end
         tick();
      end
      idle(4);

      // leave fresh data in both rdata registers, then go idle and check they hold
      disp_req = 1'b1; disp_addr = 14'h0007;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0009;
      tick(); tick();
      idle(3);
      idle(10);

      // reset with display traffic in flight
      disp_req = 1'b1; disp_addr = 14'h0051;
      tick(); tick();
      reset = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(posedge clk);
      #1;
      chk_all_zero("midrst_edge");
      reset = 1'b0;
      q.delete();
      streak = 0;
      m_disp_rd = '0;
      m_cpu_rd  = '0;
      exp_en = 1'b0;
      exp_we = 1'b0;
      cyc++;
      disp_addr = 14'h0033;
      tick();
      chk("post_rst_first_gnt", 32'(last_dg), 32'd1);
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 16Kx16 video RAM (iCE40 SPRAM, 14-bit word address) between two requesters: the VGA scanout reader and the Hack CPU's memory-mapped screen port (read/write).
- Pipelined: accepts at most one new access per cycle and has a fixed two-cycle read latency.
- Display reads have priority. A starvation counter guarantees the CPU a slot.
- Sits between the VGA block, the CPU memory decoder and the SPRAM primitive.

Parameters:
- ADDR_W, 14, VRAM word address width
- DATA_W, 16, VRAM word width
- STARVE_LIMIT, 4, number of consecutive display grants with the CPU waiting before the CPU is forced a slot (range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- disp_req  in  1  display read request; held until disp_gnt
- disp_addr  in  ADDR_W  display read address; stable while disp_req is high
- disp_gnt  out  1  display request issued this cycle
- disp_valid  out  1  one-cycle pulse; disp_rdata is valid
- disp_rdata  out  DATA_W  display read data
- cpu_req  in  1  CPU request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request issued this cycle
- cpu_ack  out  1  one-cycle pulse; access complete, cpu_rdata valid for reads
- cpu_rdata  out  DATA_W  CPU read data
- ram_addr  out  ADDR_W  registered SPRAM address
- ram_wdata  out  DATA_W  registered SPRAM write data
- ram_we  out  1  registered SPRAM write enable
- ram_en  out  1  registered SPRAM chip enable
- ram_rdata  in  DATA_W  SPRAM data, valid the cycle after the SPRAM samples its address

Behaviour:
- Reset (asynchronous) clears:
  - all outputs to 0, including ram_en, ram_we, both gnt, both valid/ack and both rdata;
  - both pipeline owner tags to NONE;
  - the starvation counter.
- Reset mid-operation discards in-flight accesses; no ack or valid follows after reset release.
- Arbitration is combinational on the current req inputs.
  - gnt is a combinational pulse in the same cycle.
  - The chosen request is registered into ram_* at the next rising edge (edge E0), with the owner tag set to DISP, CPU or NONE.
- Pipeline:
  - E0: ram_* registers load.
  - E1: SPRAM samples; tag moves to stage 2.
  - E2: ram_rdata is captured into the owner's rdata, and the owner's valid/ack is high for the cycle after E2.
  - Result: gnt cycle to valid/ack cycle is exactly 3 cycles, with no bubbles and sustained one access per cycle.
- Priority:
  - Display wins when both request, unless starve_cnt == STARVE_LIMIT; then the CPU wins.
  - A sole requester always wins.
  - With no request, ram_en = 0 and the tag is NONE.
- starve_cnt (4 bits):
  - increments on each display grant while cpu_req is high;
  - clears on a CPU grant or whenever cpu_req is low;
  - saturates at STARVE_LIMIT.
- Writes:
  - ram_we = cpu_we and ram_wdata = cpu_wdata are registered on the CPU grant.
  - cpu_ack pulses at the same latency as a read.
  - cpu_rdata keeps its previous value on writes.
  - ram_wdata is don't-care on reads and is driven 0.
- Non-owner rdata registers hold their previous values.
- Requesters may drop or change req in the cycle after gnt. A req still high after gnt is a new request.
- Read-after-write to the same address, issued in consecutive cycles, returns the new data, because SPRAM accesses are ordered by issue.
- There is no error path: out-of-range addresses do not exist (full 14-bit space).

Decomposition:
- Shared package vram_pkg holds:
  - ADDR_W and DATA_W constants;
  - owner tag enum {OWN_NONE, OWN_DISP, OWN_CPU} (2 bits).
- One natural sub-module, vram_arb_pipe: the two-stage owner-tag and data-capture pipeline.
- The arbiter and starvation counter stay in the top.

Test Plan:
- Reset: assert reset with disp_req = 1 mid-pipeline. Required: all outputs 0 immediately; after release, no stray disp_valid; first grant in the first cycle after release.
- Display-only read: preload mem[0x0051] = 0xBEEF, disp_req with disp_addr = 0x0051.
  - disp_gnt in cycle T;
  - ram_addr = 0x0051 and ram_en = 1 after T;
  - disp_valid with disp_rdata = 0xBEEF in cycle T+3.
- CPU write then read: write 0x1234 to 0x3FFF, then read 0x3FFF back-to-back.
  - two cpu_ack pulses, 1 cycle apart;
  - second ack returns cpu_rdata = 0x1234;
  - cpu_rdata unchanged after the first ack.
- Contention, STARVE_LIMIT = 4: disp_req and cpu_req both held high continuously. Required grant pattern is D,D,D,D,C repeating, with cpu_gnt every 5th cycle.
- Back-to-back mixed traffic: alternating disp and CPU reads over 64 random addresses. Required:
  - every gnt is matched by exactly one valid/ack 3 cycles later, with correct data against a reference memory model;
  - disp_gnt and cpu_gnt are never high together.
- Idle: no requests for 10 cycles. Required: ram_en = 0, ram_we = 0, no valid/ack, and rdata outputs hold their last values.
